// File: rtl/rtc_pkg.sv
// rtc_pkg: shared state encoding and command constants for the RTC bus sequencers.
package rtc_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StASetup,
    StAStrobe,
    StAHold,
    StDSetup,
    StDStrobe,
    StDHold,
    StNext,
    StDone
  } rtc_state_e;

  // RAM-to-clock transfer command: address and data of the trailing transaction
  localparam logic [7:0] RTC_CMD_ADDR = 8'hF1;
  localparam logic [7:0] RTC_CMD_XFER = 8'h08;

  localparam logic [7:0] RTC_BASE_ADDR_DEFAULT = 8'h21;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rtc_writer_if.sv
// rtc_writer_if: host-side request/data port plus the multiplexed RTC bus pins.
interface rtc_writer_if;
  logic       start;
  logic [7:0] data_idx;
  logic [7:0] wr_data;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       ad_n;
  logic       wr_n;
  logic       rd_n;
  logic       busy;
  logic       done;

  // master: the write sequencer
  modport master (
    input  start, wr_data,
    output data_idx, ad_out, ad_oe, cs_n, ad_n, wr_n, rd_n, busy, done
  );

  // slave: host + bus side (arbiter / tristate / bench)
  modport slave (
    output start, wr_data,
    input  data_idx, ad_out, ad_oe, cs_n, ad_n, wr_n, rd_n, busy, done
  );
endinterface

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: loadable down-counter; o_zero marks the last cycle of a timed phase.
module rtc_phase_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  // Load on phase entry, otherwise count down and park at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/rtc_writer.sv
// rtc_writer: writes N_WORDS consecutive RTC registers from BASE_ADDR on each start pulse.
// Optional feature macro RTC_WR_TRANSFER_EN: append the RAM-to-clock transfer command
// (addr 8'hF1, data 8'h08) after the last word.
module rtc_writer
  import rtc_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = RTC_BASE_ADDR_DEFAULT,
  parameter int unsigned N_WORDS   = 9,
  parameter int unsigned T_PULSE   = 16,
  parameter int unsigned T_GAP     = 16
) (
  input  logic         clk,
  input  logic         reset,
  rtc_writer_if.master io_bus
);

  localparam int unsigned CNT_W    = $clog2(max_u(T_PULSE, T_GAP) + 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(T_GAP - 1);
  localparam logic [7:0]  LAST_W   = 8'(N_WORDS - 1);

  rtc_state_e r_state, w_state_next;
  logic [7:0] r_w, w_w_next;
  logic [7:0] r_data, w_data_next;
  logic [7:0] r_ad_out, w_ad_out_next;
  logic       r_ad_oe, r_cs_n, r_ad_n, r_wr_n, r_busy, r_done;
  logic       w_ad_oe_next, w_cs_n_next, w_ad_n_next, w_wr_n_next;
  logic       w_xfer, w_xfer_next;
  logic       w_zero, w_load;
  logic [CNT_W-1:0] w_load_val;

`ifdef RTC_WR_TRANSFER_EN
  logic r_xfer;

  // Transfer flag: set when the last data word completes, cleared on a new start
  always_comb begin
    w_xfer_next = r_xfer;
    if (r_state == StIdle && io_bus.start) begin
      w_xfer_next = 1'b0;
    end else if (r_state == StNext && r_w == LAST_W && !r_xfer) begin
      w_xfer_next = 1'b1;
    end
  end

  // Transfer flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_xfer <= 1'b0;
    else       r_xfer <= w_xfer_next;
  end

  assign w_xfer = r_xfer;
`else
  assign w_xfer      = 1'b0;
  assign w_xfer_next = 1'b0;
`endif

  // Next-state and word-counter logic
  always_comb begin
    w_state_next = r_state;
    w_w_next     = r_w;
    case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_state_next = StASetup;
          w_w_next     = '0;
        end
      end
      StASetup:  w_state_next = StAStrobe;
      StAStrobe: if (w_zero) w_state_next = StAHold;
      StAHold:   if (w_zero) w_state_next = StDSetup;
      StDSetup:  w_state_next = StDStrobe;
      StDStrobe: if (w_zero) w_state_next = StDHold;
      StDHold:   if (w_zero) w_state_next = StNext;
      StNext: begin
        if (r_w != LAST_W) begin
          w_w_next     = r_w + 8'd1;
          w_state_next = StASetup;
        end else if (w_xfer_next && !w_xfer) begin
          // data_idx stays at the last word during the command transaction
          w_state_next = StASetup;
        end else begin
          w_state_next = StDone;
        end
      end
      StDone:    w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Reload the phase timer on every entry into a STROBE or HOLD phase
  assign w_load = (w_state_next != r_state) &&
                  (w_state_next inside {StAStrobe, StAHold, StDStrobe, StDHold});
  assign w_load_val = (w_state_next inside {StAStrobe, StDStrobe}) ? PULSE_LD : GAP_LD;

  rtc_phase_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_zero  (w_zero)
  );

  // Host data is captured once on D_SETUP entry so ad_out is stable for the data phase
  assign w_data_next = (w_state_next == StDSetup && r_state != StDSetup) ?
                       (w_xfer ? RTC_CMD_XFER : io_bus.wr_data) : r_data;

  // Bus pin values for the upcoming state; registered below so outputs are glitch-free
  always_comb begin
    w_cs_n_next   = 1'b1;
    w_ad_n_next   = 1'b1;
    w_wr_n_next   = 1'b1;
    w_ad_oe_next  = 1'b0;
    w_ad_out_next = '0;
    case (w_state_next)
      StASetup, StAStrobe, StAHold: begin
        w_cs_n_next   = 1'b0;
        w_ad_n_next   = 1'b0;
        w_ad_oe_next  = 1'b1;
        w_ad_out_next = w_xfer_next ? RTC_CMD_ADDR : BASE_ADDR + w_w_next;
        w_wr_n_next   = (w_state_next != StAStrobe);
      end
      StDSetup, StDStrobe, StDHold: begin
        w_cs_n_next   = 1'b0;
        w_ad_oe_next  = 1'b1;
        w_ad_out_next = w_data_next;
        w_wr_n_next   = (w_state_next != StDStrobe);
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_w      <= '0;
      r_data   <= '0;
      r_ad_out <= '0;
      r_ad_oe  <= 1'b0;
      r_cs_n   <= 1'b1;
      r_ad_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_w      <= w_w_next;
      r_data   <= w_data_next;
      r_ad_out <= w_ad_out_next;
      r_ad_oe  <= w_ad_oe_next;
      r_cs_n   <= w_cs_n_next;
      r_ad_n   <= w_ad_n_next;
      r_wr_n   <= w_wr_n_next;
      r_busy   <= (w_state_next != StIdle);
      r_done   <= (w_state_next == StDone);
    end
  end

  assign io_bus.data_idx = r_w;
  assign io_bus.ad_out   = r_ad_out;
  assign io_bus.ad_oe    = r_ad_oe;
  assign io_bus.cs_n     = r_cs_n;
  assign io_bus.ad_n     = r_ad_n;
  assign io_bus.wr_n     = r_wr_n;
  assign io_bus.rd_n     = 1'b1;
  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;

endmodule

// File: tb/tb_rtc_writer.sv
// tb_rtc_writer: scoreboard bench for rtc_writer (default, address-wrap and minimum-timing builds).
`timescale 1ns/1ps
module tb_rtc_writer;

  localparam int NDUT = 3;
`ifdef RTC_WR_TRANSFER_EN
  localparam int XFER = 1;
`else
  localparam int XFER = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rtc_writer_if bus0 ();
  rtc_writer_if bus1 ();
  rtc_writer_if bus2 ();

  rtc_writer #(.BASE_ADDR(8'h21), .N_WORDS(9), .T_PULSE(16), .T_GAP(16)) u_dut0 (
    .clk(clk), .reset(reset), .io_bus(bus0));
  rtc_writer #(.BASE_ADDR(8'hFE), .N_WORDS(3), .T_PULSE(16), .T_GAP(16)) u_dut1 (
    .clk(clk), .reset(reset), .io_bus(bus1));
  rtc_writer #(.BASE_ADDR(8'h21), .N_WORDS(1), .T_PULSE(1), .T_GAP(1)) u_dut2 (
    .clk(clk), .reset(reset), .io_bus(bus2));

  logic [7:0] p_base  [NDUT] = '{8'h21, 8'hFE, 8'h21};
  int         p_words [NDUT] = '{9, 3, 1};
  int         p_tp    [NDUT] = '{16, 16, 1};
  int         p_tg    [NDUT] = '{16, 16, 1};

  logic [NDUT-1:0] start_v = '0;
  assign bus0.start = start_v[0];
  assign bus1.start = start_v[1];
  assign bus2.start = start_v[2];
  assign bus0.wr_data = 8'h30 + bus0.data_idx;
  assign bus1.wr_data = 8'h30 + bus1.data_idx;
  assign bus2.wr_data = 8'h30 + bus2.data_idx;

  logic [NDUT-1:0] m_cs_n, m_ad_n, m_wr_n, m_busy, m_done;
  logic [7:0]      m_ad_out [NDUT];
  assign m_cs_n[0] = bus0.cs_n;  assign m_cs_n[1] = bus1.cs_n;  assign m_cs_n[2] = bus2.cs_n;
  assign m_ad_n[0] = bus0.ad_n;  assign m_ad_n[1] = bus1.ad_n;  assign m_ad_n[2] = bus2.ad_n;
  assign m_wr_n[0] = bus0.wr_n;  assign m_wr_n[1] = bus1.wr_n;  assign m_wr_n[2] = bus2.wr_n;
  assign m_busy[0] = bus0.busy;  assign m_busy[1] = bus1.busy;  assign m_busy[2] = bus2.busy;
  assign m_done[0] = bus0.done;  assign m_done[1] = bus1.done;  assign m_done[2] = bus2.done;
  assign m_ad_out[0] = bus0.ad_out;
  assign m_ad_out[1] = bus1.ad_out;
  assign m_ad_out[2] = bus2.ad_out;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: {addr, data} per expected transaction; only one DUT is active at a time
  logic [15:0] exp_q [$];
  int          exp_done [NDUT];

  int         lo_len    [NDUT];
  logic       prev_wr   [NDUT];
  logic       prev_busy [NDUT];
  logic [7:0] cap_addr  [NDUT];
  logic [7:0] cap_data  [NDUT];
  int         cyc       [NDUT];
  int         done_cnt  [NDUT] = '{0, 0, 0};

  // Bus monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (reset) begin
        prev_wr[i]   = 1'b1;
        prev_busy[i] = 1'b0;
        lo_len[i]    = 0;
        cyc[i]       = 0;
      end else begin
        if (m_busy[i] && !prev_busy[i]) cyc[i] = 0;
        else                            cyc[i]++;
        if (!m_wr_n[i]) begin
          check_eq("wr_low_needs_cs", 32'(m_cs_n[i]), 32'd0);
          lo_len[i]++;
          if (!m_ad_n[i]) cap_addr[i] = m_ad_out[i];
          else            cap_data[i] = m_ad_out[i];
        end else if (!prev_wr[i]) begin
          check_eq("strobe_len", 32'(lo_len[i]), 32'(p_tp[i]));
          lo_len[i] = 0;
          if (m_ad_n[i]) begin
            if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            else check_eq("txn_addr_data", {16'h0, cap_addr[i], cap_data[i]},
                          {16'h0, exp_q.pop_front()});
          end
        end
        if (m_done[i]) begin
          done_cnt[i]++;
          check_eq("done_cycle", 32'(cyc[i]), 32'(exp_done[i]));
          check_eq("sb_drained_at_done", 32'(exp_q.size()), 32'd0);
        end
        prev_wr[i]   = m_wr_n[i];
        prev_busy[i] = m_busy[i];
      end
    end
  end

  task automatic push_expected(input int i);
    logic [7:0] a, d;
    for (int k = 0; k < p_words[i]; k++) begin
      a = p_base[i] + 8'(k);
      d = 8'h30 + 8'(k);
      exp_q.push_back({a, d});
    end
    if (XFER == 1) exp_q.push_back({8'hF1, 8'h08});
    exp_done[i] = (2 * (1 + p_tp[i] + p_tg[i]) + 1) * (p_words[i] + XFER);
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk); #1 start_v[i] = 1'b1;
    @(posedge clk); #1 start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int tgt, n;
    tgt = done_cnt[i] + 1;
    n = 0;
    while (done_cnt[i] < tgt && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq("done_within_budget", 32'(done_cnt[i] >= tgt), 32'd1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cs_n",  32'(bus0.cs_n),  32'd1);
    check_eq("rst_wr_n",  32'(bus0.wr_n),  32'd1);
    check_eq("rst_rd_n",  32'(bus0.rd_n),  32'd1);
    check_eq("rst_ad_n",  32'(bus0.ad_n),  32'd1);
    check_eq("rst_ad_oe", 32'(bus0.ad_oe), 32'd0);
    check_eq("rst_ad_out", 32'(bus0.ad_out), 32'd0);
    check_eq("rst_busy",  32'(bus0.busy),  32'd0);
    check_eq("rst_done",  32'(bus0.done),  32'd0);
    check_eq("rst_idx",   32'(bus0.data_idx), 32'd0);
    reset = 1'b0;

    // Default sequence, with a start pulse mid-run that must be dropped
    push_expected(0);
    pulse_start(0);
    repeat (200) @(posedge clk);
    pulse_start(0);
    wait_done(0, 2000);
    repeat (5) @(posedge clk);
    #1;
    check_eq("busy_after_done", 32'(bus0.busy), 32'd0);
    check_eq("single_done", 32'(done_cnt[0]), 32'd1);
    check_eq("sb_empty_default", 32'(exp_q.size()), 32'd0);

    // Reset during the data strobe of word 4
    push_expected(0);
    pulse_start(0);
    n = 0;
    while (!(bus0.data_idx == 8'd4 && bus0.ad_n && !bus0.wr_n) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_w4_dstrobe", 32'(n < 2000), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_wr_n",  32'(bus0.wr_n),  32'd1);
    check_eq("midrst_cs_n",  32'(bus0.cs_n),  32'd1);
    check_eq("midrst_ad_oe", 32'(bus0.ad_oe), 32'd0);
    check_eq("midrst_busy",  32'(bus0.busy),  32'd0);
    check_eq("midrst_idx",   32'(bus0.data_idx), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Fresh start after the truncated run begins again at the base address
    push_expected(0);
    pulse_start(0);
    n = 0;
    while (bus0.cs_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("restart_first_addr", 32'(bus0.ad_out), 32'h21);
    wait_done(0, 2000);

    // Address wrap past 8'hFF
    push_expected(1);
    pulse_start(1);
    wait_done(1, 1000);

    // Minimum strobe/gap timing, single word
    push_expected(2);
    pulse_start(2);
    wait_done(2, 100);

    repeat (5) @(posedge clk);
    #1;
    check_eq("done_cnt_dut0", 32'(done_cnt[0]), 32'd2);
    check_eq("done_cnt_dut1", 32'(done_cnt[1]), 32'd1);
    check_eq("done_cnt_dut2", 32'(done_cnt[2]), 32'd1);
    check_eq("sb_empty_end", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
